// File: rtl/soc_bus_arbiter.sv
// Round-robin arbiter: two bus masters (m0 = CPU data, m1 = debug/loader) share one slave bus.
// Latency: request sampled at edge E drives s_req after E; slave ack at edge E+k gives mN_ack for one cycle after E+k.
// Backpressure: a master holds mN_req until its one-cycle mN_ack; the slave stalls by holding s_ack low.
//
// Ports: g_clk/g_rst_n (async active-low reset); per master mN_req/we/addr/wdata in and
// mN_rdata/ack/err out; slave side s_req/we/addr/wdata out, s_rdata/s_ack in.
// Optional feature macro: ARB_TIMEOUT_EN enables a BUSY wait counter that aborts a stalled
// transfer after TIMEOUT_CYCLES cycles and flags it with mN_err. Without it mN_err stays 0.
module soc_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  g_clk,
    input  logic                  g_rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  s_req,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_q, gnt_d;
    logic                  s_req_q, s_req_d;
    logic                  s_we_q, s_we_d;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  m0_ack_q, m0_ack_d;
    logic                  m1_ack_q, m1_ack_d;
    logic                  m0_err_q, m0_err_d;
    logic                  m1_err_q, m1_err_d;
    logic                  timeout_hit;
    logic                  sel;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // IDLE is the only way into BUSY, so clearing while idle is the same as clearing on entry.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_IDLE) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_BUSY && !s_ack) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // A real ack in the expiry cycle takes priority over the abort.
    assign timeout_hit = (state_q == ST_BUSY) && !s_ack && (wait_cnt_q == TMO_LIMIT);

    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) wait_cnt_q <= '0;
        else          wait_cnt_q <= wait_cnt_d;
    end
`else
    logic [7:0] unused_tmo;
    assign unused_tmo  = 8'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
`endif

    // Single requester wins outright; on a tie the master that did not win last time goes.
    assign sel = (m0_req && m1_req) ? ~last_grant_q : m1_req;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        s_req_d      = s_req_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_err_d     = 1'b0;
        m1_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    s_req_d      = 1'b1;
                    s_we_d       = sel ? m1_we    : m0_we;
                    s_addr_d     = sel ? m1_addr  : m0_addr;
                    s_wdata_d    = sel ? m1_wdata : m0_wdata;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ack/err are registered on leaving BUSY so they are high exactly during RESP.
                if (s_ack) begin
                    s_req_d = 1'b0;
                    state_d = ST_RESP;
                    if (gnt_q) begin
                        m1_rdata_d = s_rdata;
                        m1_ack_d   = 1'b1;
                    end else begin
                        m0_rdata_d = s_rdata;
                        m0_ack_d   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    s_req_d = 1'b0;
                    state_d = ST_RESP;
                    if (gnt_q) begin
                        m1_ack_d = 1'b1;
                        m1_err_d = 1'b1;
                    end else begin
                        m0_ack_d = 1'b1;
                        m0_err_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                s_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            s_req_q      <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            s_req_q      <= s_req_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_err_q     <= m0_err_d;
            m1_err_q     <= m1_err_d;
        end
    end

    assign s_req    = s_req_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter: single read, tie alternation, stalled write,
// reset mid-transfer, and (with ARB_TIMEOUT_EN) timeout abort and ack-on-expiry.
// Inputs are driven 1ns after the rising edge; outputs are sampled at the same point.
module tb_soc_bus_arbiter;

    logic        g_clk = 1'b0;
    logic        g_rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_req, s_we, s_ack;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int n_total = 0;
    int n_bad   = 0;

    always #5 g_clk = ~g_clk;

    soc_bus_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .g_clk   (g_clk),
        .g_rst_n (g_rst_n),
        .m0_req  (m0_req),
        .m0_we   (m0_we),
        .m0_addr (m0_addr),
        .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata),
        .m0_ack  (m0_ack),
        .m0_err  (m0_err),
        .m1_req  (m1_req),
        .m1_we   (m1_we),
        .m1_addr (m1_addr),
        .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata),
        .m1_ack  (m1_ack),
        .m1_err  (m1_err),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic apply_reset();
        g_rst_n  = 1'b0;
        m0_req   = 1'b0; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = 32'h0;
        m1_req   = 1'b0; m1_we = 1'b0; m1_addr = 32'h200; m1_wdata = 32'h0;
        s_ack    = 1'b0; s_rdata = 32'h0;
        repeat (2) tick();
        g_rst_n = 1'b1;
        tick();
    endtask

    // Advance until s_req rises, bounded; an expired bound counts as a failure.
    task automatic wait_s_req(input string tag);
        int n = 0;
        while (!s_req && n < 10) begin
            tick();
            n++;
        end
        if (!s_req) chk({tag, "_sreq_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int cnt;
        apply_reset();
        chk("rst_outs", {s_req, s_we, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
        chk("rst_bus",  s_addr | s_wdata | m0_rdata | m1_rdata, 32'd0);

        // m0 read 0x10, slave acks in the first s_req cycle.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        tick();
        chk("t1_sreq", {31'd0, s_req}, 32'd1);
        chk("t1_saddr", s_addr, 32'h10);
        chk("t1_ack_early", {30'd0, m0_ack, m1_ack}, 32'd0);
        s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_sreq_drop", {31'd0, s_req}, 32'd0);
        chk("t1_ack", {29'd0, m0_ack, m0_err, m1_ack}, 32'b100);
        chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        chk("t1_m1_rdata", m1_rdata, 32'd0);
        m0_req = 1'b0; s_ack = 1'b0; s_rdata = 32'h0;
        tick();
        chk("t1_ack_pulse", {31'd0, m0_ack}, 32'd0);
        chk("t1_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // Both masters requesting from reset alternate m0, m1, m0, m1.
        apply_reset();
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            wait_s_req($sformatf("t2_%0d", i));
            chk($sformatf("t2_grant%0d", i), s_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            s_ack = 1'b1; s_rdata = 32'hA0 + i;
            tick();
            s_ack = 1'b0;
            chk($sformatf("t2_ack%0d", i), {30'd0, m0_ack, m1_ack},
                (i % 2 == 0) ? 32'b10 : 32'b01);
        end
        chk("t2_m0_rdata", m0_rdata, 32'hA2);
        chk("t2_m1_rdata", m1_rdata, 32'hA3);

        // m1 write 0x20/0x1FF with a slave that stalls 3 cycles.
        apply_reset();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1FF;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("t3_busy%0d", c), {s_req, s_we, 30'd0} ^ s_addr ^ (s_wdata << 8),
                {2'b11, 30'd0} ^ 32'h20 ^ (32'h1FF << 8));
            chk($sformatf("t3_noack%0d", c), {31'd0, m1_ack}, 32'd0);
            if (c < 3) tick();
        end
        s_ack = 1'b1; s_rdata = 32'h55;
        tick();
        chk("t3_ack", {30'd0, m0_ack, m1_ack}, 32'b01);
        chk("t3_rdata", m1_rdata, 32'h55);
        chk("t3_m0_rdata", m0_rdata, 32'd0);
        m1_req = 1'b0; s_ack = 1'b0;
        tick();
        chk("t3_ack_pulse", {31'd0, m1_ack}, 32'd0);

        // Reset while BUSY: everything clears at once; tie afterwards goes to m0.
        apply_reset();
        m0_req = 1'b1; m0_addr = 32'h100;
        wait_s_req("t4a");
        s_ack = 1'b1; s_rdata = 32'hCAFE;
        tick();
        m0_req = 1'b0; s_ack = 1'b0;
        tick();
        m0_req = 1'b1;
        wait_s_req("t4b");
        g_rst_n = 1'b0;
        #2;
        chk("t4_rst_sreq", {31'd0, s_req}, 32'd0);
        chk("t4_rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        chk("t4_rst_rdata", m0_rdata, 32'd0);
        chk("t4_rst_addr", s_addr, 32'd0);
        m1_req = 1'b1;
        @(negedge g_clk);
        g_rst_n = 1'b1;
        tick();
        chk("t4_tie_m0", s_addr, 32'h100);
        chk("t4_tie_sreq", {31'd0, s_req}, 32'd1);

`ifdef ARB_TIMEOUT_EN
        // Slave never acks: abort after 5 BUSY cycles with err, rdata untouched.
        apply_reset();
        m0_req = 1'b1; m0_addr = 32'h100;
        wait_s_req("t5a");
        s_ack = 1'b1; s_rdata = 32'h1234;
        tick();
        m0_req = 1'b0; s_ack = 1'b0;
        tick();
        m0_req = 1'b1; m0_addr = 32'h104;
        wait_s_req("t5b");
        cnt = 0;
        while (s_req && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("t5_busy_cycles", cnt, 32'd5);
        chk("t5_ack_err", {30'd0, m0_ack, m0_err}, 32'b11);
        chk("t5_rdata_kept", m0_rdata, 32'h1234);
        m0_req = 1'b0;
        tick();
        chk("t5_pulse", {30'd0, m0_ack, m0_err}, 32'd0);

        // Ack arriving on the expiry cycle completes normally.
        m0_req = 1'b1; m0_addr = 32'h108;
        wait_s_req("t6");
        repeat (4) tick();
        chk("t6_still_busy", {31'd0, s_req}, 32'd1);
        s_ack = 1'b1; s_rdata = 32'hABCD;
        tick();
        m0_req = 1'b0; s_ack = 1'b0;
        chk("t6_ack_noerr", {30'd0, m0_ack, m0_err}, 32'b10);
        chk("t6_rdata", m0_rdata, 32'hABCD);
`else
        cnt = 0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
